// File: rtl/branch_pc_ctrl.sv
// Fetch-side PC controller: owns the IF program counter, carries each fetch's
// BTB prediction through ID to EXE, detects mispredicts there, drives the BTB
// update port and keeps saturating branch/mispredict statistics.
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             predict_jump,
  input  logic [31:0]      jump_addr,
  input  logic             exe_branch,
  input  logic             exe_taken,
  input  logic [31:0]      exe_target,
  output logic [31:0]      pc_if,
  output logic [31:0]      pc_exe,
  output logic             update_flag_exe,
  output logic             branch_taken_exe,
  output logic [31:0]      branch_addr_exe,
  output logic             redirect,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned PC_W = 32;

  // Prediction carried alongside each in-flight fetch.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } slot_t;

  logic [PC_W-1:0]  r_pc_if;
  slot_t            r_fid;
  slot_t            r_fex;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  logic [PC_W-1:0]  w_pred_next;
  logic [PC_W-1:0]  w_act_next;
  logic             w_redirect;
  logic             w_update;

  // EXE resolution: the slot was mispredicted whenever the address it assumed
  // would follow differs from the address that actually follows.
  assign w_pred_next = r_fex.pred_taken ? r_fex.pred_target : r_fex.pc + PC_W'(4);
  assign w_act_next  = (exe_branch && exe_taken) ? exe_target : r_fex.pc + PC_W'(4);
  assign w_redirect  = r_fex.valid && (w_pred_next != w_act_next);
  assign w_update    = r_fex.valid && exe_branch;

  assign pc_if            = r_pc_if;
  assign pc_exe           = r_fex.pc;
  assign redirect         = w_redirect;
  assign flush            = w_redirect;
  assign update_flag_exe  = w_update;
  assign branch_taken_exe = exe_taken;
  assign branch_addr_exe  = exe_target;
  assign branch_cnt       = r_branch_cnt;
  assign mispredict_cnt   = r_mispredict_cnt;

  // Fetch PC: redirect beats stall, stall beats prediction, else sequential.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_if <= RESET_PC;
    end else if (w_redirect) begin
      r_pc_if <= w_act_next;
    end else if (!stall) begin
      r_pc_if <= predict_jump ? jump_addr : r_pc_if + PC_W'(4);
    end
  end

  // IF/ID slot: squashed on redirect, frozen on stall, else captures the fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fid <= '0;
    end else if (w_redirect) begin
      r_fid.valid <= 1'b0;
    end else if (!stall) begin
      r_fid.valid       <= 1'b1;
      r_fid.pc          <= r_pc_if;
      r_fid.pred_taken  <= predict_jump;
      r_fid.pred_target <= jump_addr;
    end
  end

  // ID/EX slot: bubble on redirect or stall; pc is kept so pc_exe holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fex <= '0;
    end else if (w_redirect || stall) begin
      r_fex.valid <= 1'b0;
    end else begin
      r_fex <= r_fid;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_update && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_redirect && (r_mispredict_cnt != '1)) begin
        r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl: directed scenarios with constant
// expectations plus a randomized run against a queue-free behavioural model.
module tb_branch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        predict_jump;
  logic [31:0] jump_addr;
  logic        exe_branch;
  logic        exe_taken;
  logic [31:0] exe_target;

  logic [31:0] pc_if, pc_exe, branch_addr_exe;
  logic        update_flag_exe, branch_taken_exe, redirect, flush;
  logic [31:0] branch_cnt, mispredict_cnt;

  logic [31:0] s_pc_if, s_pc_exe, s_branch_addr_exe;
  logic        s_update_flag_exe, s_branch_taken_exe, s_redirect, s_flush;
  logic [3:0]  s_branch_cnt, s_mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pc_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .predict_jump(predict_jump),
    .jump_addr(jump_addr), .exe_branch(exe_branch), .exe_taken(exe_taken),
    .exe_target(exe_target), .pc_if(pc_if), .pc_exe(pc_exe),
    .update_flag_exe(update_flag_exe), .branch_taken_exe(branch_taken_exe),
    .branch_addr_exe(branch_addr_exe), .redirect(redirect), .flush(flush),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_pc_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .predict_jump(predict_jump),
    .jump_addr(jump_addr), .exe_branch(exe_branch), .exe_taken(exe_taken),
    .exe_target(exe_target), .pc_if(s_pc_if), .pc_exe(s_pc_exe),
    .update_flag_exe(s_update_flag_exe), .branch_taken_exe(s_branch_taken_exe),
    .branch_addr_exe(s_branch_addr_exe), .redirect(s_redirect), .flush(s_flush),
    .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
  );

  // Reference model state: fetch PC plus the two fetches in flight.
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } mslot_t;

  logic [31:0] m_pc;
  mslot_t      m_fid, m_fex;
  longint      m_br, m_mis;

  task automatic clear_inputs();
    stall = 1'b0; predict_jump = 1'b0; jump_addr = 32'h0;
    exe_branch = 1'b0; exe_taken = 1'b0; exe_target = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic walk(input int n);
    repeat (n) tick();
  endtask

  task automatic set_exe(input logic b, input logic t, input logic [31:0] tg);
    exe_branch = b; exe_taken = t; exe_target = tg;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL rst_pc_if got %h want %h", pc_if, 32'h0); end
    checks++; if (pc_exe !== 32'h0) begin errors++; $display("FAIL rst_pc_exe got %h want %h", pc_exe, 32'h0); end
    checks++; if ({redirect, flush, update_flag_exe} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b want 000", {redirect, flush, update_flag_exe}); end
    checks++; if (branch_cnt !== 32'h0 || mispredict_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h/%h want 0/0", branch_cnt, mispredict_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
    // Slots stay empty for two edges: EXE inputs must be ignored.
    set_exe(1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 2; i++) begin
      checks++; if (redirect !== 1'b0 || update_flag_exe !== 1'b0) begin errors++; $display("FAIL rst_empty_exe cyc %0d got %b%b want 00", i, redirect, update_flag_exe); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc_if !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc cyc %0d got %h want %h", i, pc_if, 32'(i * 4)); end
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL seq_redirect cyc %0d got %b want 0", i, redirect); end
      if (i >= 2) begin
        checks++; if (pc_exe !== 32'((i - 2) * 4)) begin errors++; $display("FAIL seq_pc_exe cyc %0d got %h want %h", i, pc_exe, 32'((i - 2) * 4)); end
      end
      tick();
    end
    checks++; if (branch_cnt !== 32'h0 || mispredict_cnt !== 32'h0) begin errors++; $display("FAIL seq_cnt got %h/%h want 0/0", branch_cnt, mispredict_cnt); end
  endtask

  task automatic test_not_taken_mispredict();
    do_reset();
    walk(6);
    set_exe(1'b1, 1'b1, 32'h40);
    checks++; if (pc_exe !== 32'h10) begin errors++; $display("FAIL nt_pc_exe got %h want %h", pc_exe, 32'h10); end
    checks++; if ({redirect, flush, update_flag_exe, branch_taken_exe} !== 4'b1111) begin errors++; $display("FAIL nt_strobes got %b want 1111", {redirect, flush, update_flag_exe, branch_taken_exe}); end
    checks++; if (branch_addr_exe !== 32'h40) begin errors++; $display("FAIL nt_addr got %h want %h", branch_addr_exe, 32'h40); end
    tick();
    checks++; if (pc_if !== 32'h40) begin errors++; $display("FAIL nt_target got %h want %h", pc_if, 32'h40); end
    checks++; if (redirect !== 1'b0 || update_flag_exe !== 1'b0) begin errors++; $display("FAIL nt_squash1 got %b%b want 00", redirect, update_flag_exe); end
    checks++; if (pc_exe !== 32'h10) begin errors++; $display("FAIL nt_pc_exe_hold got %h want %h", pc_exe, 32'h10); end
    checks++; if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd1) begin errors++; $display("FAIL nt_cnt got %0d/%0d want 1/1", branch_cnt, mispredict_cnt); end
    tick();
    checks++; if (redirect !== 1'b0 || update_flag_exe !== 1'b0) begin errors++; $display("FAIL nt_squash2 got %b%b want 00", redirect, update_flag_exe); end
    clear_inputs();
    tick();
    checks++; if (pc_exe !== 32'h40 || pc_if !== 32'h48) begin errors++; $display("FAIL nt_resume got %h/%h want 40/48", pc_exe, pc_if); end
  endtask

  task automatic test_correct_taken();
    do_reset();
    walk(8);
    predict_jump = 1'b1; jump_addr = 32'h80;
    tick();
    checks++; if (pc_if !== 32'h80) begin errors++; $display("FAIL ct_pc got %h want %h", pc_if, 32'h80); end
    predict_jump = 1'b0;
    tick();
    set_exe(1'b1, 1'b1, 32'h80);
    checks++; if (pc_exe !== 32'h20 || redirect !== 1'b0 || update_flag_exe !== 1'b1) begin errors++; $display("FAIL ct_exe got %h %b%b want 20 01", pc_exe, redirect, update_flag_exe); end
    tick();
    clear_inputs();
    checks++; if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd0) begin errors++; $display("FAIL ct_cnt got %0d/%0d want 1/0", branch_cnt, mispredict_cnt); end
    checks++; if (pc_if !== 32'h88) begin errors++; $display("FAIL ct_seq got %h want %h", pc_if, 32'h88); end
  endtask

  task automatic test_wrong_target();
    do_reset();
    walk(12);
    predict_jump = 1'b1; jump_addr = 32'h100;
    tick();
    predict_jump = 1'b0;
    tick();
    set_exe(1'b1, 1'b1, 32'h200);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL wt_redirect got %b want 1", redirect); end
    tick();
    clear_inputs();
    checks++; if (pc_if !== 32'h200) begin errors++; $display("FAIL wt_pc got %h want %h", pc_if, 32'h200); end
    do_reset();
    walk(13);
    predict_jump = 1'b1; jump_addr = 32'h300;
    tick();
    predict_jump = 1'b0;
    tick();
    set_exe(1'b1, 1'b0, 32'h300);
    checks++; if (redirect !== 1'b1 || branch_taken_exe !== 1'b0) begin errors++; $display("FAIL tnt_redirect got %b%b want 10", redirect, branch_taken_exe); end
    tick();
    clear_inputs();
    checks++; if (pc_if !== 32'h38) begin errors++; $display("FAIL tnt_pc got %h want %h", pc_if, 32'h38); end
  endtask

  task automatic test_stall();
    do_reset();
    walk(20);
    stall = 1'b1;
    set_exe(1'b1, 1'b0, 32'h0);
    checks++; if (update_flag_exe !== 1'b1 || pc_exe !== 32'h48) begin errors++; $display("FAIL st_first got %b %h want 1 48", update_flag_exe, pc_exe); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) stall = 1'b0;
      #1;
      checks++; if (pc_if !== 32'h50) begin errors++; $display("FAIL st_hold cyc %0d got %h want %h", i, pc_if, 32'h50); end
      checks++; if (update_flag_exe !== 1'b0 || pc_exe !== 32'h48) begin errors++; $display("FAIL st_bubble cyc %0d got %b %h want 0 48", i, update_flag_exe, pc_exe); end
    end
    checks++; if (branch_cnt !== 32'd1) begin errors++; $display("FAIL st_cnt got %0d want 1", branch_cnt); end
    tick();
    checks++; if (pc_if !== 32'h54 || pc_exe !== 32'h4C || update_flag_exe !== 1'b1) begin errors++; $display("FAIL st_resume got %h %h %b want 54 4c 1", pc_if, pc_exe, update_flag_exe); end
    // Mispredict in EXE while stalled: redirect still wins.
    stall = 1'b1;
    set_exe(1'b1, 1'b1, 32'h400);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL st_redirect got %b want 1", redirect); end
    tick();
    stall = 1'b0;
    #1;
    checks++; if (pc_if !== 32'h400) begin errors++; $display("FAIL st_redirect_pc got %h want %h", pc_if, 32'h400); end
    checks++; if (update_flag_exe !== 1'b0 || mispredict_cnt !== 32'd1) begin errors++; $display("FAIL st_redirect_flush got %b %0d want 0 1", update_flag_exe, mispredict_cnt); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    walk(2);
    set_exe(1'b1, 1'b1, 32'h40);
    tick();
    clear_inputs();
    walk(2);
    set_exe(1'b1, 1'b1, 32'h80);
    checks++; if (redirect !== 1'b1 || mispredict_cnt !== 32'd1) begin errors++; $display("FAIL mr_pre got %b %0d want 1 1", redirect, mispredict_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (pc_if !== 32'h0 || pc_exe !== 32'h0) begin errors++; $display("FAIL mr_pc got %h %h want 0 0", pc_if, pc_exe); end
    checks++; if ({redirect, flush, update_flag_exe} !== 3'b000) begin errors++; $display("FAIL mr_strobes got %b want 000", {redirect, flush, update_flag_exe}); end
    @(posedge clk);
    #1;
    checks++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin errors++; $display("FAIL mr_cnt got %0d/%0d want 0/0", branch_cnt, mispredict_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mr_after got %b want 0", redirect); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    // Constant taken-to-0x1000 resolution mispredicts every third cycle.
    exe_branch = 1'b1; exe_taken = 1'b1; exe_target = 32'h1000;
    walk(60);
    clear_inputs();
    checks++; if (s_mispredict_cnt !== 4'hF || s_branch_cnt !== 4'hF) begin errors++; $display("FAIL sat_small got %h/%h want f/f", s_branch_cnt, s_mispredict_cnt); end
    checks++; if (mispredict_cnt !== 32'd20 || branch_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide got %0d/%0d want 20/20", branch_cnt, mispredict_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    predict_jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    tick();
    predict_jump = 1'b0;
    checks++; if (pc_if !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump got %h want fffffffc", pc_if); end
    tick();
    checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc_if); end
    set_exe(1'b1, 1'b1, 32'hFFFF_FFFC);
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL wrap_exe0 got %b want 0", redirect); end
    tick();
    set_exe(1'b0, 1'b0, 32'h0);
    checks++; if (pc_exe !== 32'hFFFF_FFFC || redirect !== 1'b0) begin errors++; $display("FAIL wrap_exe1 got %h %b want fffffffc 0", pc_exe, redirect); end
  endtask

  task automatic test_random();
    logic [31:0] e_pred, e_act;
    logic        e_red, e_upd;
    logic [3:0]  e_sbr, e_smis;
    do_reset();
    m_pc = 32'h0; m_br = 0; m_mis = 0;
    m_fid = '{v: 1'b0, pc: 32'h0, pt: 1'b0, tg: 32'h0};
    m_fex = m_fid;
    for (int c = 0; c < 400; c++) begin
      stall        = ($urandom_range(3) == 0);
      predict_jump = ($urandom_range(3) == 0);
      jump_addr    = $urandom() & 32'hFFFF_FFFC;
      exe_branch   = $urandom_range(1) == 1;
      exe_taken    = ($urandom_range(1) == 1) ? m_fex.pt : ($urandom_range(1) == 1);
      exe_target   = ($urandom_range(1) == 1) ? m_fex.tg : ($urandom() & 32'hFFFF_FFFC);
      #1;
      e_pred = m_fex.pt ? m_fex.tg : m_fex.pc + 32'd4;
      e_act  = (exe_branch && exe_taken) ? exe_target : m_fex.pc + 32'd4;
      e_red  = m_fex.v && (e_pred != e_act);
      e_upd  = m_fex.v && exe_branch;
      e_sbr  = (m_br > 15) ? 4'hF : 4'(m_br);
      e_smis = (m_mis > 15) ? 4'hF : 4'(m_mis);
      checks++; if (pc_if !== m_pc || pc_exe !== m_fex.pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h %h want %h %h", c, pc_if, pc_exe, m_pc, m_fex.pc); end
      checks++; if (redirect !== e_red || flush !== e_red) begin errors++; $display("FAIL rnd_redirect cyc %0d got %b%b want %b", c, redirect, flush, e_red); end
      checks++; if ({update_flag_exe, branch_taken_exe, branch_addr_exe} !== {e_upd, exe_taken, exe_target}) begin errors++; $display("FAIL rnd_btb cyc %0d got %b %b %h want %b %b %h", c, update_flag_exe, branch_taken_exe, branch_addr_exe, e_upd, exe_taken, exe_target); end
      checks++; if (branch_cnt !== 32'(m_br) || mispredict_cnt !== 32'(m_mis)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", c, branch_cnt, mispredict_cnt, m_br, m_mis); end
      checks++; if ({s_pc_if, s_pc_exe, s_redirect, s_flush, s_update_flag_exe, s_branch_taken_exe, s_branch_addr_exe, s_branch_cnt, s_mispredict_cnt} !==
                    {m_pc, m_fex.pc, e_red, e_red, e_upd, exe_taken, exe_target, e_sbr, e_smis}) begin
        errors++; $display("FAIL rnd_small cyc %0d got %h %h %b %h/%h want %h %h %b %h/%h", c, s_pc_if, s_pc_exe, s_redirect, s_branch_cnt, s_mispredict_cnt, m_pc, m_fex.pc, e_red, e_sbr, e_smis);
      end
      if (e_upd) m_br++;
      if (e_red) m_mis++;
      if (e_red) begin
        m_pc = e_act; m_fid.v = 1'b0; m_fex.v = 1'b0;
      end else if (stall) begin
        m_fex.v = 1'b0;
      end else begin
        m_fex = m_fid;
        m_fid = '{v: 1'b1, pc: m_pc, pt: predict_jump, tg: jump_addr};
        m_pc  = predict_jump ? jump_addr : m_pc + 32'd4;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_not_taken_mispredict();
    test_correct_taken();
    test_wrong_target();
    test_stall();
    test_reset_mid_stream();
    test_saturation();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
# branch_pc_ctrl

Fetch-side PC controller wrapped around the BTB. Owns the IF program-counter register, picks the next PC from the redirect, stall, BTB prediction or sequential path, and carries each fetch's prediction through ID to EXE. In EXE it compares the prediction against the resolved outcome, raises redirect/flush on a mispredict, drives the BTB update port, and keeps branch and mispredict statistics.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- CNT_W, 32, width of statistics counters
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit freeze of the IF and ID stages
- predict_jump  in  1  BTB taken-prediction for the current pc_if
- jump_addr  in  32  BTB predicted target for pc_if
- exe_branch  in  1  instruction in EXE is a control transfer (branch/jal/jalr)
- exe_taken  in  1  resolved direction in EXE
- exe_target  in  32  resolved target in EXE
- pc_if  out  32  current fetch PC, also feeds the BTB read port
- pc_exe  out  32  PC of the EXE slot, feeds the BTB update port
- update_flag_exe  out  1  BTB update strobe
- branch_taken_exe  out  1  BTB update direction
- branch_addr_exe  out  32  BTB update target
- redirect  out  1  mispredict detected this cycle
- flush  out  1  squash IF/ID and ID/EX, equal to redirect
- branch_cnt  out  CNT_W  resolved control transfers
- mispredict_cnt  out  CNT_W  redirects taken

## Operation
- Slot registers: fid (IF/ID) and fex (ID/EX). Each slot holds {valid, pc, pred_taken, pred_target}.
- pred_next = pred_taken ? pred_target : pc+4. act_next = (exe_branch && exe_taken) ? exe_target : pc_exe+4.
- redirect = fex.valid && (pred_next != act_next). This covers all mispredict cases:
  - predicted taken, actually not taken;
  - predicted not taken, actually taken;
  - predicted taken with the wrong target;
  - predicted taken on a non-branch.
- redirect_pc = act_next.
- Next-PC priority:
  - redirect -> redirect_pc;
  - else stall -> hold;
  - else predict_jump -> jump_addr;
  - else pc_if+4.
- fid update priority:
  - redirect -> valid=0;
  - else stall -> hold;
  - else capture {1, pc_if, predict_jump, jump_addr}.
- fex update:
  - redirect or stall -> valid=0 (bubble);
  - else capture fid.
- pc_exe = fex.pc. pc_exe holds its old value while fex is invalid.
- BTB update port:
  - update_flag_exe = fex.valid && exe_branch;
  - branch_taken_exe = exe_taken;
  - branch_addr_exe = exe_target.
- Counters:
  - branch_cnt increments on update_flag_exe;
  - mispredict_cnt increments on redirect;
  - both saturate at all-ones, with no wrap.
- exe_branch, exe_taken and exe_target are ignored while fex.valid=0.

## Timing
- Reset values (asynchronous):
  - pc_if=RESET_PC, pc_exe=0;
  - fid.valid=fex.valid=0;
  - both counters 0;
  - redirect=flush=update_flag_exe=0.
- redirect, flush, update_flag_exe and the branch_* outputs are combinational from fex and the exe_* inputs. They are valid in the same cycle, and the BTB samples them on the next rising edge.
- Redirect penalty: 2 cycles, the squashed fid and fex contents. The target is fetched in the cycle after redirect.
- Correct prediction costs 0 bubbles. A predicted-taken fetch goes to jump_addr on the next edge.
- Redirect and stall in the same cycle: redirect wins. The PC loads redirect_pc, fid is cleared, and fex is cleared.
- Stall held for N cycles: pc_if and fid are frozen, and fex receives N bubbles.
- A first instruction reaches EXE no earlier than 2 edges after reset release.
- Reset asserted mid-redirect: all state returns to reset values immediately, and no counter increments.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.

## Test plan
- Sequential fetch: after reset, no branches, predict_jump=0 -> pc_if = 0, 4, 8, 12 on successive cycles; redirect never asserts; counters stay 0.
- Not-taken mispredict: branch at 0x10 predicted not taken, resolved taken to 0x40 -> in its EXE cycle redirect=1, update_flag_exe=1, branch_addr_exe=0x40; next pc_if=0x40; slots for 0x14 and 0x18 squashed; both counters = 1.
- Correct taken prediction: predict_jump=1 with jump_addr=0x80 at pc_if=0x20, resolved taken to 0x80 -> pc_if=0x80 on the next cycle; redirect=0 in EXE; branch_cnt=1, mispredict_cnt=0.
- Wrong target: pc_if=0x30 predicted to 0x100, resolved taken to 0x200 -> redirect=1, next pc_if=0x200. Also pc_if=0x34 predicted taken but resolved not taken -> next pc_if=0x38.
- Stall interaction:
  - stall for 3 cycles at pc_if=0x50 -> pc_if holds 0x50, 3 bubbles enter EXE, update_flag_exe=0 during the bubbles;
  - with stall=1 while a mispredict is in EXE -> redirect still loads its target.
- Reset and saturation:
  - assert rst mid-stream -> pc_if=RESET_PC and fex invalid immediately;
  - with CNT_W=4, 17 mispredicts -> mispredict_cnt=4'hF.
